// File: rtl/accum_32bit.sv
// Burst accumulator: sums a handshaked stream of 32-bit operands through one
// ripple-carry adder and reports the wrapped sum plus the count of carry-outs.

module fulladder_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);
   logic [32:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 32; i++) begin : g_bit
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[32];
endmodule

module accum_32bit #(
   parameter int LEN_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_sum,
   output logic [LEN_W-1:0] out_carry_cnt,
   output logic             busy,
   output logic [1:0]       dbg_state_o
);
   // Handshake: a transfer happens on a rising edge where valid && ready are
   // both high; ready/valid driven by this block come only from state_q.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      acc_q, acc_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [31:0]      res_sum_q, res_sum_d;
   logic [LEN_W-1:0] res_cnt_q, res_cnt_d;

   logic [31:0]      add_sum;
   logic             add_cout;
   logic [LEN_W-1:0] cnt_inc;

   fulladder_32bit u_adder (
      .a    (acc_q),
      .b    (in_data),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign cnt_inc = cnt_q + LEN_W'(add_cout);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         rem_q     <= '0;
         res_sum_q <= '0;
         res_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         res_sum_q <= res_sum_d;
         res_cnt_q <= res_cnt_d;
      end
   end

   // Result registers are separate from acc_q so the last result survives
   // the accumulator being cleared by the next start.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      res_sum_d = res_sum_q;
      res_cnt_d = res_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d = '0;
               cnt_d = '0;
               if (len != '0) begin
                  rem_d   = len;
                  state_d = S_ACC;
               end else begin
                  res_sum_d = '0;
                  res_cnt_d = '0;
                  state_d   = S_DONE;
               end
            end
         end
         S_ACC: begin
            if (in_valid) begin
               acc_d = add_sum;
               cnt_d = cnt_inc;
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  res_sum_d = add_sum;
                  res_cnt_d = cnt_inc;
                  state_d   = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready      = (state_q == S_ACC);
   assign out_valid     = (state_q == S_DONE);
   assign busy          = (state_q != S_IDLE);
   assign out_sum       = res_sum_q;
   assign out_carry_cnt = res_cnt_q;
   assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_accum_32bit.sv
// Bench for accum_32bit: table-driven bursts and random bursts feed a result
// queue; hand-written sequences cover hold, start-in-ACC and mid-burst reset.

module tb_accum_32bit;
   localparam int LEN_W = 5;
   localparam int RW    = LEN_W + 32;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_sum;
   logic [LEN_W-1:0] out_carry_cnt;
   logic             busy;
   logic [1:0]       dbg_state;

   accum_32bit #(.LEN_W(LEN_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .len           (len),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_sum       (out_sum),
      .out_carry_cnt (out_carry_cnt),
      .busy          (busy),
      .dbg_state_o   (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   logic [RW-1:0] exp_q[$];
   logic [31:0]   op_buf[32];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   // scoreboard: compare every consumed result against the queue head
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 64'(out_sum), 64'hDEAD_BEEF_0000_0000);
         end else begin
            logic [RW-1:0] e;
            e = exp_q.pop_front();
            check("result_sum", 64'(out_sum), 64'(e[31:0]));
            check("result_carry_cnt", 64'(out_carry_cnt), 64'(e[RW-1:32]));
         end
      end
   end

   // driver: start a burst of n operands from op_buf; optional gaps/noise
   task automatic drive_burst(input int n, input bit gaps, input bit start_noise);
      int  i;
      int  guard;
      bit  acc;
      @(posedge clk); #1;
      start = 1'b1;
      len   = LEN_W'(n);
      if (gaps) begin
         in_valid = 1'b1;
         in_data  = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
      len   = LEN_W'($urandom_range(0, 31));
      in_valid = 1'b0;
      if (n == 0) begin
         @(negedge clk);
         check("empty_out_valid", 64'(out_valid), 64'd1);
         check("empty_in_ready", 64'(in_ready), 64'd0);
         return;
      end
      i = 0;
      guard = 0;
      while (i < n && guard < 1000) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_data  = $urandom;
         end else begin
            in_valid = 1'b1;
            in_data  = op_buf[i];
         end
         if (start_noise) begin
            start = 1'($urandom_range(0, 1));
            len   = LEN_W'(7);
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) i++;
         guard++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (guard >= 1000) check("accept_timeout", 64'(i), 64'(n));
      @(negedge clk);
      check("latency_out_valid", 64'(out_valid), 64'd1);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 100) check("idle_timeout", 64'(busy), 64'd0);
   endtask

   typedef struct {
      int          n;
      logic [31:0] ops[16];
      logic [31:0] exp_sum;
      logic [4:0]  exp_cnt;
   } vec_t;

   initial begin
      vec_t vecs[6];
      logic [63:0] model;

      rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
      in_data = '0; out_ready = 1'b1;

      #2;
      check("rst_out_sum", 64'(out_sum), 64'd0);
      check("rst_out_carry_cnt", 64'(out_carry_cnt), 64'd0);
      check("rst_flags", {61'd0, in_ready, out_valid, busy}, 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      #20 rst_n = 1'b1;

      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 16; j++) vecs[i].ops[j] = 32'd0;
      vecs[0].n = 3;  vecs[0].ops[0] = 32'd1; vecs[0].ops[1] = 32'd2; vecs[0].ops[2] = 32'd3;
      vecs[0].exp_sum = 32'h0000_0006; vecs[0].exp_cnt = 5'd0;
      vecs[1].n = 2;  vecs[1].ops[0] = 32'hFFFF_FFFF; vecs[1].ops[1] = 32'h0000_0002;
      vecs[1].exp_sum = 32'h0000_0001; vecs[1].exp_cnt = 5'd1;
      vecs[2].n = 16;
      for (int j = 0; j < 16; j++) vecs[2].ops[j] = 32'hFFFF_FFFF;
      vecs[2].exp_sum = 32'hFFFF_FFF0; vecs[2].exp_cnt = 5'd15;
      vecs[3].n = 0;
      vecs[3].exp_sum = 32'h0; vecs[3].exp_cnt = 5'd0;
      vecs[4].n = 1;  vecs[4].ops[0] = 32'h8000_0000;
      vecs[4].exp_sum = 32'h8000_0000; vecs[4].exp_cnt = 5'd0;
      vecs[5].n = 2;  vecs[5].ops[0] = 32'h8000_0000; vecs[5].ops[1] = 32'h8000_0000;
      vecs[5].exp_sum = 32'h0; vecs[5].exp_cnt = 5'd1;

      for (int v = 0; v < 6; v++) begin
         for (int j = 0; j < 16; j++) op_buf[j] = vecs[v].ops[j];
         exp_q.push_back({vecs[v].exp_cnt, vecs[v].exp_sum});
         drive_burst(vecs[v].n, 1'b0, 1'b0);
         wait_idle();
      end

      // random bursts with a full-precision reference sum
      for (int r = 0; r < 12; r++) begin
         int n;
         n = $urandom_range(0, 31);
         model = 64'd0;
         for (int j = 0; j < n; j++) begin
            op_buf[j] = (r % 3 == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom;
            model = model + 64'(op_buf[j]);
         end
         exp_q.push_back({model[RW-1:32], model[31:0]});
         drive_burst(n, 1'(r % 2), 1'b0);
         wait_idle();
      end

      // len=4 of 0x10 with gaps, start pulsed in ACC, out_ready held low
      out_ready = 1'b0;
      for (int j = 0; j < 4; j++) op_buf[j] = 32'h10;
      exp_q.push_back({5'd0, 32'h0000_0040});
      drive_burst(4, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_out_valid", 64'(out_valid), 64'd1);
         check("hold_out_sum", 64'(out_sum), 64'h40);
         check("hold_carry_cnt", 64'(out_carry_cnt), 64'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_after_consume", 64'(busy), 64'd0);
      @(posedge clk); #1;
      check("no_spurious_start", 64'(busy), 64'd0);

      // reset after 2 of 5 operands
      @(posedge clk); #1;
      start = 1'b1; len = LEN_W'(5);
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1; in_data = 32'h1111_1111;
      @(posedge clk); #1;
      in_data = 32'h2222_2222;
      @(posedge clk); #3;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_flags", {61'd0, in_ready, out_valid, busy}, 64'd0);
      check("midrst_out_sum", 64'(out_sum), 64'd0);
      check("midrst_carry_cnt", 64'(out_carry_cnt), 64'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      op_buf[0] = 32'h1234_5678;
      exp_q.push_back({5'd0, 32'h1234_5678});
      drive_burst(1, 1'b0, 1'b0);
      wait_idle();

      repeat (3) @(posedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/accum_32bit.md
# accum_32bit

Sequential accumulator that sits directly upstream of `fulladder_32bit` and drives its `a`, `b` and `cin` inputs. It accepts a burst of 32-bit operands over a valid/ready handshake and adds them one per cycle through a single `fulladder_32bit` instance. It then presents the 32-bit wrapped sum together with a count of carries out of bit 31. Consumers combine the two to reconstruct the full-precision result.

## Interface
- `LEN_W`, default 5: width of the burst length and carry count; maximum burst is 2^LEN_W-1 operands.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a burst; sampled only in IDLE.
- `len` input LEN_W: number of operands in the burst, latched on an accepted `start`.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block accepts an operand this cycle.
- `in_data` input 32: operand.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: downstream consumes the result.
- `out_sum` output 32: accumulated sum modulo 2^32.
- `out_carry_cnt` output LEN_W: number of adder carry-outs during the burst.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- Adder instance wiring: `a` = accumulator register, `b` = `in_data`, `cin` = 0. The `sum` and `cout` outputs feed the update logic.
- States: IDLE, ACC, DONE. All state is registered.
- IDLE:
  - `in_ready`=0, `out_valid`=0.
  - On `start`=1 with `len`≠0: acc←0, carry_cnt←0, remaining←`len`, go to ACC.
  - On `start`=1 with `len`=0: acc←0, carry_cnt←0, go to DONE (empty burst; result 0).
- ACC:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: acc←adder `sum`, carry_cnt←carry_cnt+`cout`, remaining←remaining-1.
  - If remaining was 1, go to DONE.
  - `in_valid`=0 cycles hold all state.
- DONE:
  - `out_valid`=1; `out_sum`=acc; `out_carry_cnt`=carry_cnt.
  - Outputs are held stable until `out_ready`=1, then go to IDLE.
- `start` is ignored outside IDLE, including while `in_valid` is high in ACC.
- `in_data` presented outside ACC is ignored and never accepted.
- Carry count cannot overflow: at most len-1 carries occur, and len-1 ≤ 2^LEN_W-2.
- Full-precision result = `out_carry_cnt`·2^32 + `out_sum`.
- `out_sum` and `out_carry_cnt` retain their last values in IDLE and ACC. They are meaningful only while `out_valid`=1.

## Timing
- Reset (`rst_n`=0, asynchronous, effective immediately):
  - state=IDLE.
  - acc, remaining, carry_cnt = 0.
  - `in_ready`=0, `out_valid`=0, `busy`=0, `out_sum`=0, `out_carry_cnt`=0.
- Reset asserted mid-burst aborts the burst with no result. The first `start` after deassertion behaves normally.
- `start` in cycle N: `in_ready`=1 from cycle N+1 (or `out_valid`=1 from N+1 if `len`=0).
- Throughput: one operand per cycle with `in_valid` held high. A burst of L operands occupies L cycles of ACC at best.
- Latency: `out_valid` rises the cycle after the last operand is accepted.
- `out_valid`&&`out_ready` in cycle M: IDLE in M+1. A `start` in M+1 is accepted, so the minimum gap between bursts is one IDLE cycle.
- `in_ready`, `out_valid` and `busy` are decoded from the registered state only. They have no combinational path from any input.
- The 32-bit ripple add through the adder instance completes within one clock period. This is the block's critical path.

## Test plan
- `len`=3, operands 1, 2, 3 back-to-back -> `out_sum`=0x00000006, `out_carry_cnt`=0, `out_valid` high exactly one cycle after the third accept.
- `len`=2, operands 0xFFFFFFFF, 0x00000002 -> `out_sum`=0x00000001, `out_carry_cnt`=1.
- `len`=16, 16× 0xFFFFFFFF back-to-back -> `out_sum`=0xFFFFFFF0, `out_carry_cnt`=15.
- `len`=4, operands 0x10 each, with `in_valid` gaps, `start` pulsed during ACC, and `out_ready` held low 5 cycles in DONE -> `out_sum`=0x00000040. The extra `start` has no effect, and outputs stay stable until `out_ready`.
- `len`=0 -> `out_valid`=1 the next cycle, `out_sum`=0, `out_carry_cnt`=0, `in_ready` never high.
- `rst_n` pulsed low after 2 of 5 operands -> all outputs 0 immediately. A following `len`=1 burst with 0x12345678 gives `out_sum`=0x12345678, `out_carry_cnt`=0.
